bist_controller: RTL and testbench



---
 rtl/bist_controller.sv | 124 ++++++++++++
 tb/tb_bist_controller.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/bist_controller.sv
// BIST sequencing controller: seeds the LFSR/scan/MISR wrapper, runs a fixed
// number of pattern cycles, drains the wrapper pipeline, then captures and
// judges the MISR signature.
//
// state | meaning
// IDLE  | waiting for start, wrapper out of reset, not in BIST mode
// SEED  | wrapper held in reset for two cycles while BIST mode is selected
// RUN   | PATTERN_COUNT cycles of LFSR patterns applied to the CUT
// DRAIN | two cycles to flush the scan register and MISR latency
// DONE  | signature captured, pass/fail held until the next launch
module bist_controller #(
  parameter int                WIDTH         = 4,
  parameter int                PATTERN_COUNT = 15,
  parameter logic [WIDTH-1:0]  GOLDEN_SIG    = {WIDTH{1'b0}},
  parameter int                CNT_W         = $clog2(PATTERN_COUNT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] misr_signature,
  output logic             bist_rstn,
  output logic             bist_mode,
  output logic             scan_en,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH-1:0] sig_captured,
  output logic [CNT_W-1:0] run_count
);

  typedef enum logic [2:0] {IDLE, SEED, RUN, DRAIN, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_RUN = CNT_W'(PATTERN_COUNT - 1);
  localparam logic [CNT_W-1:0] RC_MAX  = CNT_W'(PATTERN_COUNT);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   rc_q, rc_d;
  logic [WIDTH-1:0]   sig_q, sig_d;
  logic               pass_q, pass_d;
  logic               bist_rstn_q, bist_mode_q, busy_q, done_q;

  // Next-state, shared SEED/RUN/DRAIN down-counter and result capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rc_d    = rc_q;
    sig_d   = sig_q;
    pass_d  = pass_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = SEED;
          cnt_d   = CNT_ONE;
        end
      end
      SEED: begin
        if (cnt_q == '0) begin
          state_d = RUN;
          cnt_d   = CNT_RUN;
          rc_d    = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      RUN: begin
        if (rc_q != RC_MAX) rc_d = rc_q + CNT_ONE;
        if (cnt_q == '0) begin
          state_d = DRAIN;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      DRAIN: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          sig_d   = misr_signature;
          pass_d  = (misr_signature == GOLDEN_SIG);
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; wrapper controls decoded from the next state so they are
  // registered and aligned with the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rc_q        <= '0;
      sig_q       <= '0;
      pass_q      <= 1'b0;
      bist_rstn_q <= 1'b0;
      bist_mode_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rc_q        <= rc_d;
      sig_q       <= sig_d;
      pass_q      <= pass_d;
      bist_rstn_q <= (state_d != SEED);
      bist_mode_q <= (state_d == SEED) || (state_d == RUN) || (state_d == DRAIN);
      busy_q      <= (state_d == SEED) || (state_d == RUN) || (state_d == DRAIN);
      done_q      <= (state_d == DONE);
    end
  end

  assign bist_rstn    = bist_rstn_q;
  assign bist_mode    = bist_mode_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign sig_captured = sig_q;
  assign run_count    = rc_q;
  assign scan_en      = 1'b0;

endmodule

// File: tb/tb_bist_controller.sv
// Bench for bist_controller: three instances (defaults, non-zero golden
// signature, single-pattern run) with expected results held in a scoreboard.
module tb_bist_controller;

  logic            clk;
  logic            rst;
  logic [2:0]      start_v;
  logic [2:0][3:0] misr_v;
  wire  [2:0]      bist_rstn_v, bist_mode_v, scan_en_v, busy_v, done_v, pass_v;
  wire  [2:0][3:0] sigc_v;
  wire  [2:0][3:0] rc_v;
  wire             rc_p1;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int         k;
    logic       exp_pass;
    logic [3:0] exp_sig;
    int         exp_rc;
  } exp_t;
  exp_t sb[$];

  bist_controller u_def (
    .clk(clk), .rst(rst), .start(start_v[0]), .misr_signature(misr_v[0]),
    .bist_rstn(bist_rstn_v[0]), .bist_mode(bist_mode_v[0]), .scan_en(scan_en_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
    .sig_captured(sigc_v[0]), .run_count(rc_v[0])
  );

  bist_controller #(.GOLDEN_SIG(4'hA)) u_gld (
    .clk(clk), .rst(rst), .start(start_v[1]), .misr_signature(misr_v[1]),
    .bist_rstn(bist_rstn_v[1]), .bist_mode(bist_mode_v[1]), .scan_en(scan_en_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
    .sig_captured(sigc_v[1]), .run_count(rc_v[1])
  );

  bist_controller #(.PATTERN_COUNT(1)) u_p1 (
    .clk(clk), .rst(rst), .start(start_v[2]), .misr_signature(misr_v[2]),
    .bist_rstn(bist_rstn_v[2]), .bist_mode(bist_mode_v[2]), .scan_en(scan_en_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]),
    .sig_captured(sigc_v[2]), .run_count(rc_p1)
  );
  assign rc_v[2] = {3'b000, rc_p1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Outputs that must sit at their reset values while rst is high.
  task automatic check_reset_vals(input int k);
    check("rst_busy",      int'(busy_v[k]),      0);
    check("rst_done",      int'(done_v[k]),      0);
    check("rst_bist_mode", int'(bist_mode_v[k]), 0);
    check("rst_bist_rstn", int'(bist_rstn_v[k]), 0);
    check("rst_scan_en",   int'(scan_en_v[k]),   0);
    check("rst_pass",      int'(pass_v[k]),      0);
    check("rst_sig",       int'(sigc_v[k]),      0);
    check("rst_run_count", int'(rc_v[k]),        0);
  endtask

  // One launch on instance k; start is kept high through cycle hold_last.
  task automatic do_run(input int k, input int p, input logic [3:0] sig, input int hold_last);
    logic [3:0] golden;
    exp_t       e;
    bit         got;
    golden = (k == 1) ? 4'hA : 4'h0;
    sb.push_back('{k: k, exp_pass: (sig == golden), exp_sig: sig, exp_rc: p});
    start_v[k] = 1'b1;
    misr_v[k]  = ~sig;
    got = 1'b0;
    for (int c = 1; c <= p + 10 && !got; c++) begin
      tick;
      start_v[k] = (c <= hold_last);
      misr_v[k]  = (c == p + 4) ? sig : ~sig;
      if (c <= p + 5) begin
        check("busy",      int'(busy_v[k]),      int'(c <= p + 4));
        check("bist_rstn", int'(bist_rstn_v[k]), int'(!(c == 1 || c == 2)));
        check("bist_mode", int'(bist_mode_v[k]), int'(c <= p + 4));
        check("scan_en",   int'(scan_en_v[k]),   0);
      end
      if (c == 3)     check("run_count_start", int'(rc_v[k]), 0);
      if (c == p + 3) check("run_count_end",   int'(rc_v[k]), p);
      if (done_v[k]) begin
        got = 1'b1;
        check("done_latency", c, p + 5);
        if (sb.size() == 0) begin
          check("scoreboard_empty", 0, 1);
        end else begin
          e = sb.pop_front();
          check("sb_instance",  k,                 e.k);
          check("pass",         int'(pass_v[k]),   int'(e.exp_pass));
          check("sig_captured", int'(sigc_v[k]),   int'(e.exp_sig));
          check("run_count",    int'(rc_v[k]),     e.exp_rc);
        end
      end
    end
    if (!got) check("done_timeout", 0, 1);
  endtask

  // DONE must hold its results while the MISR input wanders.
  task automatic hold_done(input int k, input int n, input logic ep, input logic [3:0] es);
    for (int i = 0; i < n; i++) begin
      misr_v[k] = 4'($urandom);
      tick;
      check("hold_done", int'(done_v[k]), 1);
      check("hold_busy", int'(busy_v[k]), 0);
      check("hold_pass", int'(pass_v[k]), int'(ep));
      check("hold_sig",  int'(sigc_v[k]), int'(es));
    end
  endtask

  initial begin
    rst     = 1'b0;
    start_v = '0;
    misr_v  = '0;

    // Async reset before any clock edge.
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) check_reset_vals(k);
    tick;
    tick;
    rst = 1'b0;
    tick;
    for (int k = 0; k < 3; k++) begin
      check("idle_bist_rstn", int'(bist_rstn_v[k]), 1);
      check("idle_bist_mode", int'(bist_mode_v[k]), 0);
      check("idle_done",      int'(done_v[k]),      0);
      check("idle_busy",      int'(busy_v[k]),      0);
    end

    // Nominal pass, then relaunch from DONE with a failing signature.
    do_run(0, 15, 4'h0, 0);
    hold_done(0, 3, 1'b1, 4'h0);
    do_run(0, 15, 4'h3, 0);
    hold_done(0, 2, 1'b0, 4'h3);

    // Non-zero golden: mismatch then match.
    do_run(1, 15, 4'h5, 0);
    hold_done(1, 2, 1'b0, 4'h5);
    do_run(1, 15, 4'hA, 0);

    // Start held high through cycle 10 gives one run.
    do_run(0, 15, 4'h0, 10);
    hold_done(0, 2, 1'b1, 4'h0);

    // Abort in RUN at cycle 8, released at cycle 10.
    start_v[0] = 1'b1;
    tick;
    start_v[0] = 1'b0;
    for (int c = 2; c <= 8; c++) tick;
    check("abort_running", int'(busy_v[0]), 1);
    #2 rst = 1'b1;
    #1;
    check_reset_vals(0);
    tick;
    tick;
    rst = 1'b0;
    tick;
    check("abort_bist_rstn", int'(bist_rstn_v[0]), 1);
    check("abort_done",      int'(done_v[0]),      0);
    check("abort_pass",      int'(pass_v[0]),      0);
    check("abort_run_count", int'(rc_v[0]),        0);
    do_run(0, 15, 4'h0, 0);

    // Single-pattern boundary.
    do_run(2, 1, 4'h0, 0);
    hold_done(2, 2, 1'b1, 4'h0);

    check("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
